// File: rtl/prio_encoder_rr.sv
// Registered N-line priority encoder with sticky pending bits,
// fixed/round-robin selection and a valid/ready output handshake.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   in_valid  - qualifies in_req this cycle
//   in_req    - request bits, bit k = line k
//   mode      - 0 fixed (highest index wins), 1 round-robin
//   out_valid - out_idx holds a granted index
//   out_ready - consumer accepts out_idx this cycle
//   out_idx   - encoded index of granted line
//   pend      - current pending register
module prio_encoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;

  logic         free;
  logic         grant;
  logic [W-1:0] sel_fix;
  logic [W-1:0] sel_rr;
  logic         found;
  logic [W-1:0] sel;
  logic [N-1:0] gmask;
  int           j;

  assign free  = ~out_valid_q | out_ready;
  assign grant = free & (|pend_q);

  // Ascending scan, so the last hit is the highest index.
  always_comb begin
    sel_fix = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) sel_fix = W'(i);
    end
  end

  // Scan ptr, ptr+1, ... wrapping at N (N need not be 2**W).
  always_comb begin
    sel_rr = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && pend_q[j]) begin
        found  = 1'b1;
        sel_rr = W'(j);
      end
    end
  end

  assign sel = mode ? sel_rr : sel_fix;

  always_comb begin
    gmask = '0;
    if (grant) gmask[sel] = 1'b1;
  end

  always_comb begin
    // Set wins over the grant clear.
    pend_d      = (pend_q & ~gmask) | (in_valid ? in_req : '0);
    out_valid_d = grant | (out_valid_q & ~out_ready);
    out_idx_d   = out_idx_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_idx_d = sel;
      if (mode) begin
        if (sel == W'(N - 1)) ptr_d = '0;
        else                  ptr_d = sel + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr (N=8 and N=5 instances).
// Directed scenarios plus randomized traffic against a reference model.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, mode, out_ready, out_valid;
  logic [7:0] in_req, pend;
  logic [2:0] out_idx;

  logic       in5_valid, mode5, out5_ready, out5_valid;
  logic [4:0] in5_req, pend5;
  logic [2:0] out5_idx;

  prio_encoder_rr #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_req(in_req),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .pend(pend)
  );

  prio_encoder_rr #(.N(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in5_valid), .in_req(in5_req),
    .mode(mode5), .out_valid(out5_valid), .out_ready(out5_ready),
    .out_idx(out5_idx), .pend(pend5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state for the N=8 instance.
  bit [7:0] m_pend;
  int       m_ptr;
  bit       m_ov;
  int       m_idx;

  // Drive the N=8 inputs for one cycle, advance the model, sample at +1.
  task automatic step(input bit rst, input bit iv, input bit [7:0] req,
                      input bit md, input bit rdy);
    bit       grant;
    int       sel;
    bit [7:0] g;
    rst_n     = !rst;
    in_valid  = iv;
    in_req    = req;
    mode      = md;
    out_ready = rdy;
    if (rst) begin
      m_pend = '0;
      m_ptr  = 0;
      m_ov   = 0;
      m_idx  = 0;
    end else begin
      grant = (!m_ov || rdy) && (m_pend != 0);
      sel   = 0;
      g     = '0;
      if (grant) begin
        if (!md) begin
          for (int k = 7; k >= 0; k--)
            if (m_pend[k]) begin sel = k; break; end
        end else begin
          for (int k = 0; k < 8; k++)
            if (m_pend[(m_ptr + k) % 8]) begin
              sel = (m_ptr + k) % 8;
              break;
            end
        end
        g[sel] = 1'b1;
        m_idx  = sel;
        if (md) m_ptr = (sel + 1) % 8;
      end
      m_ov   = grant || (m_ov && !rdy);
      m_pend = (m_pend & ~g) | (iv ? req : 8'h00);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(1, 1, 8'hFF, 0, 1);
      n_cmp++;
      if (out_valid !== 1'b0 || pend !== 8'h00 || out_idx !== 3'd0) begin
        n_bad++;
        $display("FAIL reset c%0d: ov=%b pend=%h idx=%0d, want 0/00/0",
                 c, out_valid, pend, out_idx);
      end
    end
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 8'h00, 0, 1);
      n_cmp++;
      if (out_valid !== 1'b0 || pend !== 8'h00) begin
        n_bad++;
        $display("FAIL post_reset c%0d: ov=%b pend=%h, want 0/00",
                 c, out_valid, pend);
      end
    end
  endtask

  task automatic test_fixed_sweep();
    bit [7:0] v;
    step(1, 0, 0, 0, 1);
    for (int r = 1; r < 256; r++) begin
      v = 8'(r);
      step(0, 1, v, 0, 1);
      n_cmp++;
      if (pend !== v || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_latch req=%h: pend=%h ov=%b, want %h/0",
                 v, pend, out_valid, v);
      end
      for (int k = 7; k >= 0; k--) begin
        if (v[k]) begin
          step(0, 0, 0, 0, 1);
          n_cmp++;
          if (out_valid !== 1'b1 || out_idx !== 3'(k)) begin
            n_bad++;
            $display("FAIL sweep_order req=%h: ov=%b idx=%0d, want 1/%0d",
                     v, out_valid, out_idx, k);
          end
        end
      end
      step(0, 0, 0, 0, 1);
      n_cmp++;
      if (out_valid !== 1'b0 || pend !== 8'h00) begin
        n_bad++;
        $display("FAIL sweep_empty req=%h: ov=%b pend=%h, want 0/00",
                 v, out_valid, pend);
      end
    end
  endtask

  task automatic test_round_robin();
    step(1, 0, 0, 1, 1);
    step(0, 1, 8'hFF, 1, 1);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 1, 1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 3'(k)) begin
        n_bad++;
        $display("FAIL rr_ff k%0d: ov=%b idx=%0d, want 1/%0d",
                 k, out_valid, out_idx, k);
      end
    end
    step(0, 1, 8'h81, 1, 1);
    n_cmp++;
    if (out_valid !== 1'b0 || pend !== 8'h81) begin
      n_bad++;
      $display("FAIL rr_gap: ov=%b pend=%h, want 0/81", out_valid, pend);
    end
    step(0, 0, 0, 1, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL rr_wrap0: ov=%b idx=%0d, want 1/0", out_valid, out_idx);
    end
    step(0, 0, 0, 1, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
      n_bad++;
      $display("FAIL rr_wrap7: ov=%b idx=%0d, want 1/7", out_valid, out_idx);
    end
    step(0, 0, 0, 1, 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_drain: ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'h48, 0, 0);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 3'd6 || pend !== 8'h08) begin
        n_bad++;
        $display("FAIL bp_hold c%0d: ov=%b idx=%0d pend=%h, want 1/6/08",
                 c, out_valid, out_idx, pend);
      end
    end
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3 || pend !== 8'h00) begin
      n_bad++;
      $display("FAIL bp_release: ov=%b idx=%0d pend=%h, want 1/3/00",
               out_valid, out_idx, pend);
    end
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty: ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_set_wins();
    step(1, 0, 0, 0, 1);
    step(0, 1, 8'h10, 0, 1);
    step(0, 1, 8'h10, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || pend[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL setwins_1: ov=%b idx=%0d pend=%h, want 1/4/10",
               out_valid, out_idx, pend);
    end
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || pend !== 8'h00) begin
      n_bad++;
      $display("FAIL setwins_2: ov=%b idx=%0d pend=%h, want 1/4/00",
               out_valid, out_idx, pend);
    end
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL setwins_end: ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_random();
    bit [7:0] r;
    step(1, 0, 0, 0, 1);
    for (int c = 0; c < 4000; c++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), r,
           1'($urandom), ($urandom_range(0, 3) != 0));
      n_cmp++;
      if (out_valid !== m_ov || out_idx !== 3'(m_idx) || pend !== m_pend) begin
        n_bad++;
        $display("FAIL random c%0d: ov=%b idx=%0d pend=%h, want %b/%0d/%h",
                 c, out_valid, out_idx, pend, m_ov, m_idx, m_pend);
      end
    end
  endtask

  task automatic test_n5();
    step(1, 0, 0, 0, 1);
    in5_valid  = 1;
    in5_req    = 5'h1F;
    mode5      = 1;
    out5_ready = 1;
    step(0, 0, 0, 0, 1);
    in5_valid = 0;
    in5_req   = 0;
    n_cmp++;
    if (pend5 !== 5'h1F || out5_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL n5_latch: pend=%h ov=%b, want 1f/0", pend5, out5_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 1);
      n_cmp++;
      if (out5_valid !== 1'b1 || out5_idx !== 3'(k)) begin
        n_bad++;
        $display("FAIL n5_rr k%0d: ov=%b idx=%0d, want 1/%0d",
                 k, out5_valid, out5_idx, k);
      end
    end
    in5_valid = 1;
    in5_req   = 5'h01;
    step(0, 0, 0, 0, 1);
    in5_valid = 0;
    in5_req   = 0;
    n_cmp++;
    if (out5_valid !== 1'b0 || pend5 !== 5'h01) begin
      n_bad++;
      $display("FAIL n5_gap: ov=%b pend=%h, want 0/01", out5_valid, pend5);
    end
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if (out5_valid !== 1'b1 || out5_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL n5_wrap: ov=%b idx=%0d, want 1/0", out5_valid, out5_idx);
    end
    for (int c = 0; c < 400; c++) begin
      in5_valid  = 1'($urandom);
      in5_req    = 5'($urandom);
      mode5      = 1'($urandom);
      out5_ready = ($urandom_range(0, 3) != 0);
      step(0, 0, 0, 0, 1);
      if (out5_valid === 1'b1) begin
        n_cmp++;
        if (out5_idx > 3'd4) begin
          n_bad++;
          $display("FAIL n5_range c%0d: idx=%0d, want <=4", c, out5_idx);
        end
      end
    end
    in5_valid  = 0;
    in5_req    = 0;
    out5_ready = 1;
  endtask

  initial begin
    rst_n      = 0;
    in_valid   = 0;
    in_req     = 0;
    mode       = 0;
    out_ready  = 1;
    in5_valid  = 0;
    in5_req    = 0;
    mode5      = 0;
    out5_ready = 1;
    test_reset();
    test_fixed_sweep();
    test_round_robin();
    test_backpressure();
    test_set_wins();
    test_random();
    test_n5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the 8:3 combinational encoder.
- Accumulates request bits from N input lines into a sticky pending register.
- Emits one encoded index per grant through a valid/ready output handshake.
- Two selectable modes: fixed highest-index priority, or round-robin. Sits between request sources (interrupt/event lines) and a single downstream consumer.

Parameters:
N, 8, number of request lines; legal range N ≥ 2; need not be a power of two.
W, $clog2(N), output index width; derived from N, never overridden.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  qualifies in_req this cycle
in_req  input  N  request bits; bit k = line k
mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin
out_valid  output  1  out_idx holds a granted index
out_ready  input  1  consumer accepts out_idx this cycle
out_idx  output  W  encoded index of granted line
pend  output  N  current pending register (status/debug)

Behaviour:
- Reset: with rst_n=0 at a rising edge, the block clears all state regardless of other inputs.
  - pend=0, ptr=0, out_valid=0, out_idx=0.
  - Reset mid-operation discards all pending requests and any un-accepted output.
- Slot free (combinational): free = ~out_valid | out_ready.
- Grant condition: free & |pend. Grant selects only from the registered pend; same-cycle in_req is never granted in that cycle.
- Index selection:
  - mode=0: sel = highest set index of pend. ptr is unchanged.
  - mode=1: sel = first set index scanning ptr, ptr+1, …, N-1, then 0, …, ptr-1. On grant, ptr <= (sel == N-1) ? 0 : sel+1.
  - mode is sampled per grant. ptr is retained across mode changes.
- On grant: out_idx <= sel, out_valid <= 1.
- Handshake:
  - out_valid & out_ready with no grant: out_valid <= 0.
  - out_valid & ~out_ready: out_valid and out_idx hold stable, and no grant occurs.
- Pending update, every cycle:
  - pend <= (pend & ~G) | (in_valid ? in_req : 0).
  - G is the one-hot of sel when a grant occurs, else 0.
  - Set wins: a bit re-requested in its own grant cycle stays pending and is granted again later.
  - Repeated requests on an already-pending bit merge; there is no counting and no overflow.
- Latency: in_req presented in cycle t with an idle output → pend bit visible at t+1 → out_valid=1 at t+2.
- Throughput: with out_ready held high, one grant per cycle; back-to-back out_valid with no bubble.
- Empty: pend=0 and output accepted → out_valid drops to 0 in the next cycle.
- Non-power-of-2 N: out_idx never exceeds N-1. Round-robin wraps from N-1 to 0.

Test Plan:
- Reset: rst_n=0 for 3 cycles while in_valid=1, in_req=8'hFF → out_valid=0, pend=0 throughout. After release with in_req=0, out_valid stays 0.
- Fixed-mode sweep (mode=0, out_ready=1): for every in_req value 1..255, apply for one cycle, then idle.
  - First out_idx at t+2 equals the highest set bit.
  - Full drain order is descending. Example: 8'b1010_0100 → 7, 5, 2 on consecutive cycles, then out_valid=0.
- Round-robin (mode=1, out_ready=1, ptr=0):
  - One-cycle 8'hFF → out_idx 0,1,2,…,7 consecutively.
  - Then 8'b1000_0001 → 0, 7 (ptr wrapped to 0).
- Backpressure: pend holds bits 3 and 6, mode=0, out_ready=0 for 5 cycles.
  - out_valid=1 and out_idx=6 are stable; pend=8'b0000_1000.
  - Raise out_ready → 3 next cycle, then out_valid=0.
- Set-wins collision: in mode=0 with bit 4 being granted, assert in_valid with in_req=8'b0001_0000 in the grant cycle → pend[4] stays 1; out_idx=4 is emitted twice.
- N=5 (W=3), mode=1, in_req=5'b11111 → 0,1,2,3,4. A following 5'b00001 → 0; out_idx never ≥5.
